mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (A/B) arbiter in front of a single-port 8x8 memory decoder.
// Latency: request sampled in IDLE, gnt pulses in the next cycle (ACCESS), rvalid/rdata one cycle after that (DONE).
// Backpressure: none queued; requests are sampled only in IDLE, a req dropped before sampling is lost without a gnt.
// Build option: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; default build gives A fixed priority.

module mem_arbiter (
    input  logic       clk,
    input  logic       reset,

    input  logic       a_req,
    input  logic       a_we,
    input  logic [2:0] a_adr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,

    input  logic       b_req,
    input  logic       b_we,
    input  logic [2:0] b_adr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,

    output logic       mem_rw,
    output logic       mem_enable,
    output logic [2:0] mem_adr,
    output logic [7:0] mem_inputs,
    input  logic [7:0] mem_outputs
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0] state_q, state_d;

    // Copy of the winning request, held from the IDLE sample through DONE
    logic       win_b_q, win_b_d;
    logic       we_q,    we_d;
    logic [2:0] adr_q,   adr_d;
    logic [7:0] wdata_q, wdata_d;

    // Per-requester read data, each only touched by its own reads
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;

    logic any_req;
    logic pick_b;
    logic in_idle;
    logic in_access;
    logic in_done;

    assign any_req   = a_req | b_req;
    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign in_done   = (state_q == ST_DONE);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // prio_b_q = 1 means B wins the next tie; cleared by reset so A goes first
    logic prio_b_q, prio_b_d;

    assign pick_b = b_req & (~a_req | prio_b_q);

    // Pointer moves to the other requester whenever a grant decision is made
    always_comb begin
        prio_b_d = prio_b_q;
        if (in_idle && any_req) begin
            prio_b_d = ~pick_b;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end
`else
    // Fixed priority: B only wins when A is not asking
    assign pick_b = b_req & ~a_req;
`endif

    // Sequencing: IDLE -> ACCESS -> DONE -> IDLE, leaving IDLE only on a request
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = any_req ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's command when arbitration happens, hold it otherwise
    always_comb begin
        win_b_d = win_b_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        if (in_idle && any_req) begin
            win_b_d = pick_b;
            we_d    = pick_b ? b_we    : a_we;
            adr_d   = pick_b ? b_adr   : a_adr;
            wdata_d = pick_b ? b_wdata : a_wdata;
        end
    end

    // Memory read data is captured on the ACCESS-to-DONE edge into the winner's register
    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (in_access && !we_q) begin
            if (win_b_q) begin
                b_rdata_d = mem_outputs;
            end else begin
                a_rdata_d = mem_outputs;
            end
        end
    end

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            win_b_q   <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 3'd0;
            wdata_q   <= 8'd0;
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            win_b_q   <= win_b_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Requester-side handshakes: one gnt in ACCESS, rvalid in DONE for reads only
    assign a_gnt    = in_access & ~win_b_q;
    assign b_gnt    = in_access &  win_b_q;
    assign a_rvalid = in_done & ~we_q & ~win_b_q;
    assign b_rvalid = in_done & ~we_q &  win_b_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

    // Memory side is forced to a harmless read-of-address-0 pattern outside ACCESS
    assign mem_enable = in_access;
    assign mem_rw     = in_access ? ~we_q   : 1'b1;
    assign mem_adr    = in_access ? adr_q   : 3'd0;
    assign mem_inputs = in_access ? wdata_q : 8'd0;

`ifndef SYNTHESIS
    // At most one grant and one rvalid per cycle
    a_one_gnt: assert property (@(posedge clk) disable iff (reset) !(a_gnt && b_gnt));
    a_one_rvalid: assert property (@(posedge clk) disable iff (reset) !(a_rvalid && b_rvalid));
    // With the decoder disabled the memory bus must be in its safe pattern
    a_safe_bus: assert property (@(posedge clk) disable iff (reset)
        !mem_enable |-> (mem_rw && (mem_adr == 3'd0) && (mem_inputs == 8'd0)));
    // The spare state encoding is never reached
    a_legal_state: assert property (@(posedge clk) disable iff (reset) state_q != 2'd3);
`endif

endmodule
